// File: rtl/challenge_descrambler.sv
// challenge_descrambler: receive-side inverse of the keyed rotate/XOR
// challenge scrambler. It regenerates the round keys from an 8-bit LFSR
// session state and peels the rounds off in reverse order. The session state
// advances once per delivered challenge, so it stays in step with the
// scrambling end.
// Optional feature: define CHALLENGE_DESCRAMBLER_CNT_EN to add the
// saturating 16-bit challenge_count output.
module challenge_descrambler #(
   parameter int         ROUNDS = 4,
   parameter logic [7:0] SEED   = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] scrambled_challenge,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] recovered_challenge,
   input  logic       sync_load,
   input  logic [7:0] sync_seed
`ifdef CHALLENGE_DESCRAMBLER_CNT_EN
   ,
   output logic [15:0] challenge_count
`endif
);

   typedef enum logic [1:0] {IDLE, WIND, UNWIND, DONE} state_t;

   localparam logic [3:0] LAST = 4'(ROUNDS - 1);

   state_t     state_q, state_d;
   logic [7:0] s_q, s_d;
   logic [7:0] x_q, x_d;
   logic [7:0] k_q, k_d;
   logic [7:0] rec_q, rec_d;
   logic [3:0] cnt_q, cnt_d;
   logic       out_valid_q, out_valid_d;
   logic [7:0] x_round;
`ifdef CHALLENGE_DESCRAMBLER_CNT_EN
   logic [15:0] count_q, count_d;
`endif

   // Forward LFSR step, shared with the scrambling end.
   function automatic logic [7:0] lfsr_step(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   // Exact inverse of lfsr_step: walks the key sequence backwards.
   function automatic logic [7:0] lfsr_inv(input logic [7:0] n);
      return {n[0] ^ n[6] ^ n[5] ^ n[4], n[7:1]};
   endfunction

   // 8-bit rotate right; amount 0 leaves the value untouched.
   function automatic logic [7:0] rotr8(input logic [7:0] x, input logic [2:0] n);
      logic [15:0] d;
      d = {x, x} >> n;
      return d[7:0];
   endfunction

   // Next-state, datapath and output decisions for the wind/unwind sequence.
   always_comb begin
      state_d     = state_q;
      s_d         = s_q;
      x_d         = x_q;
      k_d         = k_q;
      rec_d       = rec_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      x_round     = rotr8(x_q, k_q[2:0]) ^ k_q;
`ifdef CHALLENGE_DESCRAMBLER_CNT_EN
      count_d     = count_q;
`endif
      case (state_q)
         IDLE: begin
            // A resync request takes priority over a new challenge.
            if (sync_load) begin
               s_d = (sync_seed == 8'h00) ? SEED : sync_seed;
`ifdef CHALLENGE_DESCRAMBLER_CNT_EN
               count_d = 16'h0000;
`endif
            end else if (in_valid) begin
               x_d     = scrambled_challenge;
               k_d     = s_q;
               cnt_d   = 4'd0;
               state_d = WIND;
            end
         end
         WIND: begin
            // Run the key forward to the last round's key.
            k_d = lfsr_step(k_q);
            if (cnt_q == LAST) begin
               cnt_d   = 4'd0;
               state_d = UNWIND;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         UNWIND: begin
            // Undo one round, then step the key back to the previous round.
            x_d = x_round;
            k_d = lfsr_inv(k_q);
            if (cnt_q == LAST) begin
               cnt_d       = 4'd0;
               rec_d       = x_round;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               s_d         = lfsr_step(s_q);
               state_d     = IDLE;
`ifdef CHALLENGE_DESCRAMBLER_CNT_EN
               if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and output registers; reset discards any in-flight challenge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         s_q         <= SEED;
         rec_q       <= 8'h00;
         cnt_q       <= 4'd0;
         out_valid_q <= 1'b0;
`ifdef CHALLENGE_DESCRAMBLER_CNT_EN
         count_q     <= 16'h0000;
`endif
      end else begin
         state_q     <= state_d;
         s_q         <= s_d;
         rec_q       <= rec_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
`ifdef CHALLENGE_DESCRAMBLER_CNT_EN
         count_q     <= count_d;
`endif
      end
   end

   // Working value and round key; always reloaded before use, so no reset.
   always_ff @(posedge clk) begin
      x_q <= x_d;
      k_q <= k_d;
   end

   assign in_ready            = (state_q == IDLE);
   assign out_valid           = out_valid_q;
   assign recovered_challenge = rec_q;
`ifdef CHALLENGE_DESCRAMBLER_CNT_EN
   assign challenge_count     = count_q;
`endif

endmodule
